steer_en_sm: RTL and testbench
==============================

STEER_EN_SM -- requirements
Module: steer_en_sm

Interface
REQ-001 The block SHALL have parameter MIN_RIDER_WEIGHT, default 12'h200: minimum summed load-cell reading that counts as a rider present.
REQ-002 The block SHALL have parameter FAST_SIM, default 0: when 1, the enable timer is shortened for simulation.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port ld_vld, input, 1 bit: single-cycle strobe marking new lft_ld/rght_ld samples from the A2D interface.
REQ-006 The block SHALL have port lft_ld, input, 12 bits: left load-cell reading, unsigned.
REQ-007 The block SHALL have port rght_ld, input, 12 bits: right load-cell reading, unsigned.
REQ-008 The block SHALL have port en_steer, output, 1 bit: steering enabled (consumed by the balance/steer core).
REQ-009 The block SHALL have port rider_off, output, 1 bit: no rider on platform (consumed by the auth/power block).

Function
REQ-010 On a clk edge with ld_vld=1, the block SHALL latch lft_ld and rght_ld into internal registers lft_q and rght_q; these registers SHALL otherwise hold their value.
REQ-011 The block SHALL compute sum = lft_q + rght_q as a 13-bit unsigned value, with no overflow possible.
REQ-012 The block SHALL compute diff = |lft_q - rght_q| as a 12-bit unsigned value.
REQ-013 The block SHALL define the following conditions on the latched values, evaluated every cycle:
- present = (sum >= MIN_RIDER_WEIGHT)
- balanced = (diff < sum>>2), i.e. within 25%
- step_off = (diff > sum - (sum>>4)), i.e. the lighter side carries under about 3%
REQ-014 The block SHALL implement a state machine with three states: IDLE, WAIT and STEER.
REQ-015 In any state, if present=0, the next state SHALL be IDLE; this rule has priority over every other transition.
REQ-016 In IDLE, if present=1, the next state SHALL be WAIT and the timer SHALL be cleared.
REQ-017 In WAIT, the timer SHALL behave as follows:
- if balanced=0, the timer SHALL clear and the state SHALL remain WAIT;
- if balanced=1, the timer SHALL increment by 1 each clk;
- when balanced=1 and the timer is at its terminal count, the next state SHALL be STEER.
REQ-018 In STEER, if step_off=1, the next state SHALL be WAIT with the timer cleared; otherwise the state SHALL remain STEER, including when balanced=0 but step_off=0.
REQ-019 The timer SHALL be 26 bits wide. Terminal count SHALL be:
- 26'h3FF_FFFF when FAST_SIM=0 (2^26 clocks, about 1.34 s at 50 MHz);
- low 15 bits all ones when FAST_SIM=1.
REQ-020 The timer SHALL not wrap in WAIT, because reaching terminal count leaves WAIT; in IDLE and STEER it SHALL be held at 0.
REQ-021 The block SHALL drive en_steer = (state==STEER) and rider_off = (state==IDLE), both decoded directly from the state register with no combinational path from inputs.
REQ-022 Latency: a sample strobed at edge N SHALL first affect the state at edge N+1, and the outputs SHALL reflect that new state immediately after edge N+1.
REQ-023 If ld_vld coincides with a state transition, the transition SHALL use the previously latched values, and the new sample SHALL take effect one cycle later.
REQ-024 If balanced=0 for a single cycle in WAIT, the full timer interval SHALL restart from 0.
REQ-025 When sum=0, balanced evaluates false and step_off evaluates false; present=0 SHALL dominate, so the state goes to IDLE.

Reset
REQ-026 While rst=1, asynchronously, the block SHALL force state=IDLE, timer=0, lft_q=0 and rght_q=0, giving en_steer=0 and rider_off=1.
REQ-027 Reset asserted mid-count or in STEER SHALL abandon all progress; after release, the full timer interval SHALL be required again.
REQ-028 After rst deasserts, the block SHALL take no action until the first ld_vld.

Verification
REQ-029 Reset, then lft=12'h100 and rght=12'h050 strobed (sum 0x150 < 0x200) -> rider_off=1 and en_steer=0 held indefinitely.
REQ-030 With FAST_SIM=1, strobe lft=12'h110 and rght=12'h100 (sum 0x210, diff 0x10 < 0x84) -> rider_off falls 1 cycle after the strobe; en_steer rises exactly 2^15 clocks after entering WAIT.
REQ-031 In WAIT, strobe lft=12'h180 and rght=12'h090 (diff 0xF0 >= 0x84) for one sample midway, then restore balance -> timer restarts at 0, and en_steer is delayed by the full interval from the restore.
REQ-032 In STEER, strobe lft=12'h200 and rght=12'h004 (diff 0x1FC > 0x1E4) -> en_steer=0 one cycle later, state WAIT, rider_off=0.
REQ-033 In STEER, strobe lft=12'h180 and rght=12'h0A0 (unbalanced but not step_off) -> en_steer remains 1.
REQ-034 Assert rst for 1 cycle while in STEER -> en_steer=0 and rider_off=1 immediately (asynchronously); after release and a fresh balanced strobe, the full timer interval is required again.

Source files
------------

// File: rtl/steer_en_sm.sv
// Rider-detect / steering-enable state machine: latches load-cell samples and
// enables steering once the rider has stood balanced for the full timer interval.
module steer_en_sm #(
    parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
    parameter bit          FAST_SIM         = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEER
    } state_t;

    state_t      state;
    logic [25:0] timer;
    logic [11:0] lft_q;
    logic [11:0] rght_q;
    logic [12:0] sum;
    logic [11:0] diff;
    logic        present;
    logic        balanced;
    logic        step_off;
    logic        tc_hit;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
        end else if (ld_vld) begin
            lft_q  <= lft_ld;
            rght_q <= rght_ld;
        end
    end

    assign sum      = {1'b0, lft_q} + {1'b0, rght_q};
    assign diff     = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
    assign present  = (sum >= {1'b0, MIN_RIDER_WEIGHT});
    assign balanced = ({1'b0, diff} < (sum >> 2));
    assign step_off = ({1'b0, diff} > (sum - (sum >> 4)));

    // Fast-sim only looks at the low 15 bits; the count starts at 0 so it still hits 0x7FFF first.
    assign tc_hit = FAST_SIM ? (timer[14:0] == 15'h7FFF) : (timer == 26'h3FF_FFFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else if (!present) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= WAIT;
                    timer <= '0;
                end
                WAIT: begin
                    if (!balanced) begin
                        timer <= '0;
                    end else if (tc_hit) begin
                        state <= STEER;
                        timer <= '0;
                    end else begin
                        timer <= timer + 26'd1;
                    end
                end
                STEER: begin
                    timer <= '0;
                    if (step_off) state <= WAIT;
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign en_steer  = (state == STEER);
    assign rider_off = (state == IDLE);

endmodule

// File: tb/tb_steer_en_sm.sv
// Scoreboard bench for steer_en_sm (FAST_SIM=1): stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_steer_en_sm;

    localparam int INTERVAL = 32768;

    logic        clk;
    logic        rst;
    logic        ld_vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    typedef struct {
        int    cyc;
        logic  en;
        logic  roff;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;

    steer_en_sm #(
        .MIN_RIDER_WEIGHT(12'h200),
        .FAST_SIM        (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_vld   (ld_vld),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .en_steer (en_steer),
        .rider_off(rider_off)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle; late entries count as misses.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            compared = compared + 1;
            if (e.cyc != cyc || en_steer !== e.en || rider_off !== e.roff) begin
                mismatched = mismatched + 1;
                $display("FAIL %s @cyc %0d (due %0d): got en_steer=%b rider_off=%b, want en_steer=%b rider_off=%b",
                         e.name, cyc, e.cyc, en_steer, rider_off, e.en, e.roff);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic en, input logic roff, input string name);
        exp_t x;
        x.cyc  = at;
        x.en   = en;
        x.roff = roff;
        x.name = name;
        sb.push_back(x);
    endtask

    // Presents one sample; n returns the edge index that latches it.
    task automatic strobe(input logic [11:0] l, input logic [11:0] r, output int n);
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        n       = cyc + 1;
        tick();
        ld_vld  = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic settle(input int budget);
        int k = 0;
        while (sb.size() > 0 && k < budget) begin
            tick();
            k++;
        end
        if (sb.size() > 0) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL settle_timeout: %0d expectations still pending, required 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    initial begin
        int n, u, r;
        rst     = 1'b1;
        ld_vld  = 1'b0;
        lft_ld  = '0;
        rght_ld = '0;
        tick();
        tick();
        push(cyc, 1'b0, 1'b1, "reset_state");
        settle(10);
        rst = 1'b0;
        tick();
        push(cyc + 3, 1'b0, 1'b1, "post_reset_idle");
        settle(10);

        // Light load: rider never detected.
        strobe(12'h100, 12'h050, n);
        push(n + 1,   1'b0, 1'b1, "light_n1");
        push(n + 5,   1'b0, 1'b1, "light_n5");
        push(n + 100, 1'b0, 1'b1, "light_n100");
        settle(200);

        // Balanced rider: WAIT after one cycle, STEER after the full interval.
        strobe(12'h110, 12'h100, n);
        push(n,                    1'b0, 1'b1, "idle_at_strobe");
        push(n + 1,                1'b0, 1'b0, "enter_wait");
        push(n + INTERVAL,         1'b0, 1'b0, "wait_before_tc");
        push(n + INTERVAL + 1,     1'b1, 1'b0, "steer_at_tc");
        settle(INTERVAL + 100);

        // Unbalanced but not stepping off: steering stays enabled.
        strobe(12'h180, 12'h0A0, n);
        push(n + 1,  1'b1, 1'b0, "unbal_steer_n1");
        push(n + 10, 1'b1, 1'b0, "unbal_steer_n10");
        settle(50);

        // Asynchronous reset in STEER.
        rst = 1'b1;
        push(cyc, 1'b0, 1'b1, "async_reset");
        tick();
        rst = 1'b0;
        push(cyc + 2, 1'b0, 1'b1, "after_reset_idle");
        settle(10);

        // Fresh balanced strobe, then one unbalanced sample midway restarts the timer.
        strobe(12'h110, 12'h100, n);
        push(n + 1, 1'b0, 1'b0, "rewait_enter");
        settle(10);
        wait_until(n + 4000);
        strobe(12'h180, 12'h090, u);
        strobe(12'h110, 12'h100, r);
        push(u + 1,                1'b0, 1'b0, "restart_still_wait");
        push(n + 1 + INTERVAL,     1'b0, 1'b0, "no_early_steer");
        push(r + INTERVAL - 1,     1'b0, 1'b0, "restart_before_tc");
        push(r + INTERVAL,         1'b1, 1'b0, "restart_steer");
        settle(INTERVAL + 100);

        // Step-off from STEER drops back to WAIT.
        strobe(12'h200, 12'h004, n);
        push(n,     1'b1, 1'b0, "stepoff_at_strobe");
        push(n + 1, 1'b0, 1'b0, "stepoff_wait");
        push(n + 4, 1'b0, 1'b0, "stepoff_hold_wait");
        settle(20);

        // Load removed from WAIT, then zero sum: present=0 forces IDLE.
        strobe(12'h010, 12'h010, n);
        push(n + 1, 1'b0, 1'b1, "light_from_wait");
        settle(20);
        strobe(12'h000, 12'h000, n);
        push(n + 2, 1'b0, 1'b1, "zero_sum_idle");
        settle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
